// File: rtl/sw_word_loader.sv
// sw_word_loader: assembles a WIDTH-bit word from CHUNK-bit switch slices.
// Each load press stores one slice and moves the slice pointer forward.
// A commit press copies the whole staged word into word_out in one step.
// Optional macro DEBOUNCE_EN adds a synchroniser and debounce counter on
// the load and commit keys.
//
// Output protocol: word_valid is a one-cycle strobe with no ready. It is
// high in exactly the cycle that word_out first shows a newly committed
// word. err is a one-cycle strobe for a commit press while not full.
// dbg_state exposes the FSM state (0 = FILL, 1 = FULL).
module sw_word_loader #(
    parameter int WIDTH     = 16,
    parameter int CHUNK     = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [CHUNK-1:0]                   sw_data,
    input  logic                               load,
    input  logic                               commit,
    output logic [WIDTH-1:0]                   word_out,
    output logic                               word_valid,
    output logic                               full,
    output logic [$clog2(WIDTH/CHUNK)-1:0]     ptr,
    output logic                               err,
    output logic [CHUNK-1:0]                   led_view,
    output logic                               dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int PTR_W  = $clog2(NCHUNK);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NCHUNK - 1);

    // Reject parameter sets that cannot form a whole multi-slice word.
    if ((WIDTH % CHUNK) != 0 || NCHUNK < 2 || DB_CYCLES < 1) begin : g_bad_params
        $error("sw_word_loader: illegal WIDTH/CHUNK/DB_CYCLES");
    end

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_n;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_n;
    logic [PTR_W-1:0]   w_ptr_inc;
    logic [PTR_W-1:0]   w_last_idx;
    logic [CHUNK-1:0]   r_slices [NCHUNK];
    logic [WIDTH-1:0]   w_staging;
    logic [WIDTH-1:0]   r_word;
    logic               r_word_valid;
    logic               r_err;
    logic               r_load_q;
    logic               r_commit_q;
    logic               w_load_lvl;
    logic               w_commit_lvl;
    logic               w_load_ev;
    logic               w_commit_ev;
    logic               w_commit_ok;
    logic               w_err_n;
    logic               w_wr;

`ifdef DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    // Index 0 is load, index 1 is commit.
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_db;
    logic [CNT_W-1:0] r_cnt [2];

    // Synchronise both keys, then flip each debounced level only after
    // DB_CYCLES consecutive clocks of disagreement.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_db    <= 2'b11;
            for (int k = 0; k < 2; k++) r_cnt[k] <= '0;
        end else begin
            r_sync1 <= {commit, load};
            r_sync2 <= r_sync1;
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] != r_db[k]) begin
                    if (r_cnt[k] == CNT_W'(DB_CYCLES - 1)) begin
                        r_db[k]  <= r_sync2[k];
                        r_cnt[k] <= '0;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + 1'b1;
                    end
                end else begin
                    r_cnt[k] <= '0;
                end
            end
        end
    end

    assign w_load_lvl   = r_db[0];
    assign w_commit_lvl = r_db[1];
`else
    assign w_load_lvl   = load;
    assign w_commit_lvl = commit;
`endif

    // Rising-edge events; history resets high so a held key is ignored.
    assign w_load_ev   = w_load_lvl & ~r_load_q;
    assign w_commit_ev = w_commit_lvl & ~r_commit_q;

    // Flatten the slice array into the word that a commit would publish.
    always_comb begin
        w_staging = '0;
        for (int i = 0; i < NCHUNK; i++) w_staging[i*CHUNK +: CHUNK] = r_slices[i];
    end

    // Next state: commit is judged first; a successful commit drops a
    // same-cycle load, a failed one lets the load through.
    always_comb begin
        w_state_n   = r_state;
        w_ptr_n     = r_ptr;
        w_wr        = 1'b0;
        w_commit_ok = 1'b0;
        w_err_n     = 1'b0;
        w_ptr_inc   = (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
        if (w_commit_ev) begin
            if (r_state == S_FULL) begin
                w_commit_ok = 1'b1;
                w_state_n   = S_FILL;
                w_ptr_n     = '0;
            end else begin
                w_err_n = 1'b1;
            end
        end
        if (w_load_ev && !w_commit_ok) begin
            w_wr    = 1'b1;
            w_ptr_n = w_ptr_inc;
            if (r_state == S_FILL && r_ptr == LAST) w_state_n = S_FULL;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FILL;
        else       r_state <= w_state_n;
    end

    // Datapath registers: pointer, slices, committed word and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_err        <= 1'b0;
            r_load_q     <= 1'b1;
            r_commit_q   <= 1'b1;
            for (int i = 0; i < NCHUNK; i++) r_slices[i] <= '0;
        end else begin
            r_ptr        <= w_ptr_n;
            r_word_valid <= w_commit_ok;
            r_err        <= w_err_n;
            r_load_q     <= w_load_lvl;
            r_commit_q   <= w_commit_lvl;
            if (w_wr)        r_slices[r_ptr] <= sw_data;
            if (w_commit_ok) r_word          <= w_staging;
        end
    end

    // LEDs show the most recently written slice, one behind the pointer.
    assign w_last_idx = (r_ptr == '0) ? LAST : r_ptr - 1'b1;
    assign led_view   = r_slices[w_last_idx];

    assign word_out   = r_word;
    assign word_valid = r_word_valid;
    assign err        = r_err;
    assign ptr        = r_ptr;
    assign full       = (r_state == S_FULL);
    assign dbg_state  = r_state;

endmodule
